// File: rtl/window_analysis_readout_ctrl.sv
// Autonomous drain of the window_analysis result FIFO onto a valid/ready port.
// Optional HOLD timeout enabled by defining WA_READOUT_TIMEOUT_EN.
module window_analysis_readout_ctrl #(
   parameter int unsigned READ_DATA_SIZE  = 20,
   parameter int unsigned FIFO_STATE_SIZE = 4,
   parameter int unsigned READ_LATENCY    = 2,
   parameter int unsigned COUNT_SIZE      = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 64
) (
   input  logic                       clk,
   input  logic                       rst_in,
   input  logic                       enable_in,
   input  logic [FIFO_STATE_SIZE-1:0] fifo_state_in,
   input  logic [READ_DATA_SIZE-1:0]  fifo_data_in,
   output logic                       fifo_read_enable_out,
   output logic [READ_DATA_SIZE-1:0]  result_data_out,
   output logic                       result_valid_out,
   input  logic                       result_ready_in,
   input  logic                       clear_overflow_in,
   output logic                       overflow_out,
   output logic [COUNT_SIZE-1:0]      read_count_out,
   output logic                       busy_out,
   output logic                       timeout_out
);

   localparam int unsigned LAT_W = 3;

   if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..7");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_e;

   state_e                    state_q, state_d;
   logic [LAT_W-1:0]          lat_q, lat_d;
   logic [READ_DATA_SIZE-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic [COUNT_SIZE-1:0]     count_q, count_d;
   logic                      ovf_q, ovf_d;
   logic                      busy_q, busy_d;
   logic                      strobe_q, strobe_d;
   logic                      fifo_full, fifo_empty;
   logic                      unused_flags;

   assign fifo_full    = fifo_state_in[3];
   assign fifo_empty   = fifo_state_in[2];
   assign unused_flags = ^fifo_state_in[1:0];

`ifdef WA_READOUT_TIMEOUT_EN
   localparam int unsigned HOLD_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              tmo_q, tmo_d;
`endif

   // Next-state and registered-output computation.
   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      data_d   = data_q;
      valid_d  = valid_q;
      count_d  = count_q;
      strobe_d = 1'b0;
      ovf_d    = fifo_full ? 1'b1 : (clear_overflow_in ? 1'b0 : ovf_q);
`ifdef WA_READOUT_TIMEOUT_EN
      hold_d   = hold_q;
      tmo_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (enable_in && !fifo_empty) begin
               state_d  = S_ISSUE;
               strobe_d = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            lat_d   = LAT_W'(READ_LATENCY - 1);
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               data_d  = fifo_data_in;
               valid_d = 1'b1;
               state_d = S_HOLD;
`ifdef WA_READOUT_TIMEOUT_EN
               hold_d  = '0;
`endif
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_HOLD: begin
            // A handshake on the last allowed cycle beats the timeout.
            if (result_ready_in) begin
               valid_d = 1'b0;
               count_d = count_q + COUNT_SIZE'(1);
               state_d = S_IDLE;
            end
`ifdef WA_READOUT_TIMEOUT_EN
            else if (hold_q == HOLD_W'(TIMEOUT_CYCLES - 1)) begin
               valid_d = 1'b0;
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         lat_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         strobe_q <= strobe_d;
      end
   end

`ifdef WA_READOUT_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst_in) begin
         hold_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         tmo_q  <= tmo_d;
      end
   end
   assign timeout_out = tmo_q;
`else
   assign timeout_out = 1'b0;
`endif

   assign fifo_read_enable_out = strobe_q;
   assign result_data_out      = data_q;
   assign result_valid_out     = valid_q;
   assign overflow_out         = ovf_q;
   assign read_count_out       = count_q;
   assign busy_out             = busy_q;

endmodule

// File: tb/tb_window_analysis_readout_ctrl.sv
// Directed bench for window_analysis_readout_ctrl with a transaction-level model
// and a latency-exact FIFO model; timeout cases build under WA_READOUT_TIMEOUT_EN.
module tb_window_analysis_readout_ctrl;

   localparam int unsigned DW = 20;
   localparam int unsigned SW = 4;
   localparam int unsigned L  = 2;
   localparam int unsigned CW = 16;
`ifdef WA_READOUT_TIMEOUT_EN
   localparam int unsigned TMO    = 8;
   localparam bit          TMO_EN = 1'b1;
`else
   localparam int unsigned TMO    = 64;
   localparam bit          TMO_EN = 1'b0;
`endif
   localparam logic [DW-1:0] GARBAGE = 20'h0BAD0;

   logic          clk;
   logic          rst_in, enable_in, result_ready_in, clear_overflow_in;
   logic [SW-1:0] fifo_state_in;
   logic [DW-1:0] fifo_data_in;
   logic          fifo_read_enable_out, result_valid_out, overflow_out, busy_out, timeout_out;
   logic [DW-1:0] result_data_out;
   logic [CW-1:0] read_count_out;

   window_analysis_readout_ctrl #(
      .READ_DATA_SIZE(DW), .FIFO_STATE_SIZE(SW), .READ_LATENCY(L),
      .COUNT_SIZE(CW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_in(rst_in), .enable_in(enable_in),
      .fifo_state_in(fifo_state_in), .fifo_data_in(fifo_data_in),
      .fifo_read_enable_out(fifo_read_enable_out),
      .result_data_out(result_data_out), .result_valid_out(result_valid_out),
      .result_ready_in(result_ready_in), .clear_overflow_in(clear_overflow_in),
      .overflow_out(overflow_out), .read_count_out(read_count_out),
      .busy_out(busy_out), .timeout_out(timeout_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // FIFO model: word popped on the strobe appears on fifo_data_in only for the capture edge.
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] delivered[$];
   logic [DW-1:0] pipe_d[0:L];
   bit            pipe_v[0:L];
   bit            full_force;
   int            strobes, vcycles, tmo_pulses;

   // Transaction-level model: m_t counts cycles since the strobe cycle.
   bit            m_txn;
   int            m_t;
   logic [DW-1:0] m_word, m_data;
   logic [CW-1:0] m_count;
   bit            m_valid, m_ovf, m_busy, m_strobe, m_tmo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_fifo();
      fifo_state_in = {full_force, (fifo_q.size() == 0), 2'b00};
      fifo_data_in  = pipe_v[L] ? pipe_d[L] : GARBAGE;
   endtask

   task automatic model_step();
      if (rst_in) begin
         m_txn = 0; m_t = 0; m_valid = 0; m_data = '0; m_count = '0;
         m_ovf = 0; m_busy = 0; m_strobe = 0; m_tmo = 0;
         return;
      end
      m_strobe = 0;
      m_tmo    = 0;
      if (fifo_state_in[3]) m_ovf = 1;
      else if (clear_overflow_in) m_ovf = 0;
      if (!m_txn) begin
         if (enable_in && !fifo_state_in[2]) begin
            m_txn = 1; m_t = 0; m_strobe = 1;
         end
      end else if (m_valid) begin
         if (result_ready_in) begin
            m_valid = 0; m_count = m_count + 16'd1; m_txn = 0;
         end else if (TMO_EN && (m_t - int'(L)) == int'(TMO)) begin
            m_valid = 0; m_tmo = 1; m_txn = 0;
         end else begin
            m_t++;
         end
      end else begin
         if (m_t == int'(L)) begin
            m_valid = 1; m_data = m_word;
         end
         m_t++;
      end
      m_busy = m_txn;
   endtask

   task automatic compare_all();
      check("strobe", 32'(fifo_read_enable_out), 32'(m_strobe));
      check("valid",  32'(result_valid_out),     32'(m_valid));
      check("data",   32'(result_data_out),      32'(m_data));
      check("count",  32'(read_count_out),       32'(m_count));
      check("ovf",    32'(overflow_out),         32'(m_ovf));
      check("busy",   32'(busy_out),             32'(m_busy));
      check("tmo",    32'(timeout_out),          32'(m_tmo));
   endtask

   task automatic cycle();
      logic [DW-1:0] w;
      drive_fifo();
      if (!rst_in && result_valid_out && result_ready_in) delivered.push_back(result_data_out);
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      if (fifo_read_enable_out) strobes++;
      if (result_valid_out) vcycles++;
      if (timeout_out) tmo_pulses++;
      for (int i = int'(L); i > 0; i--) begin
         pipe_d[i] = pipe_d[i-1];
         pipe_v[i] = pipe_v[i-1];
      end
      pipe_v[0] = 0;
      pipe_d[0] = GARBAGE;
      if (fifo_read_enable_out) begin
         w = (fifo_q.size() != 0) ? fifo_q.pop_front() : GARBAGE;
         pipe_d[0] = w;
         pipe_v[0] = 1;
         m_word    = w;
      end
      drive_fifo();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_valid(input int max, input string name);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         cycle();
         if (result_valid_out) seen = 1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_strobe(input int max, input string name);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         cycle();
         if (fifo_read_enable_out) seen = 1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [CW-1:0] c0;
      rst_in = 1; enable_in = 0; result_ready_in = 0; clear_overflow_in = 0; full_force = 0;
      for (int i = 0; i <= int'(L); i++) begin pipe_v[i] = 0; pipe_d[i] = GARBAGE; end
      m_word = GARBAGE;
      strobes = 0; vcycles = 0; tmo_pulses = 0;
      drive_fifo();

      // Reset, then enabled with an empty FIFO
      run(3);
      check("rst_valid", 32'(result_valid_out), 32'd0);
      check("rst_data",  32'(result_data_out),  32'd0);
      check("rst_count", 32'(read_count_out),   32'd0);
      check("rst_busy",  32'(busy_out),         32'd0);
      rst_in = 0; enable_in = 1;
      run(20);
      check("empty_no_strobe", 32'(strobes), 32'd0);
      check("empty_idle",      32'(busy_out), 32'd0);

      // Single read, ready tied high
      result_ready_in = 1; vcycles = 0;
      fifo_q.push_back(20'hA5C3F);
      run(10);
      check("single_data",   32'(result_data_out), 32'h000A5C3F);
      check("single_count",  32'(read_count_out),  32'd1);
      check("single_strobe", 32'(strobes),         32'd1);
      check("single_vcyc",   32'(vcycles),         32'd1);

      // Backpressure with three preloaded words
      rst_in = 1; run(1); rst_in = 0;
      result_ready_in = 0; strobes = 0; delivered.delete();
      fifo_q.push_back(20'h11111); fifo_q.push_back(20'h22222); fifo_q.push_back(20'h33333);
      wait_valid(10, "bp_first_valid");
      run(10);
      check("bp_hold_data",   32'(result_data_out), 32'h00011111);
      check("bp_hold_strobe", 32'(strobes),         32'd1);
      result_ready_in = 1;
      run(30);
      check("bp_ndeliv", 32'(delivered.size()), 32'd3);
      if (delivered.size() == 3) begin
         check("bp_w0", 32'(delivered[0]), 32'h00011111);
         check("bp_w1", 32'(delivered[1]), 32'h00022222);
         check("bp_w2", 32'(delivered[2]), 32'h00033333);
      end
      check("bp_count",   32'(read_count_out), 32'd3);
      check("bp_strobes", 32'(strobes),        32'd3);
      check("bp_idle",    32'(busy_out),       32'd0);

      // Sticky overflow, clear, and full-beats-clear
      full_force = 1; run(1); full_force = 0;
      check("ovf_set", 32'(overflow_out), 32'd1);
      run(3);
      check("ovf_sticky", 32'(overflow_out), 32'd1);
      clear_overflow_in = 1; run(1); clear_overflow_in = 0;
      check("ovf_clear", 32'(overflow_out), 32'd0);
      full_force = 1; clear_overflow_in = 1; run(1);
      full_force = 0; clear_overflow_in = 0;
      check("ovf_set_wins", 32'(overflow_out), 32'd1);
      run(2);

      // enable_in dropped during WAIT
      strobes = 0; c0 = read_count_out;
      fifo_q.push_back(20'h44444); fifo_q.push_back(20'h55555);
      wait_strobe(10, "en_drop_strobe");
      run(1);
      enable_in = 0;
      run(20);
      check("en_drop_strobes", 32'(strobes),         32'd1);
      check("en_drop_count",   32'(read_count_out),  32'(c0 + 16'd1));
      check("en_drop_data",    32'(result_data_out), 32'h00044444);
      check("en_drop_idle",    32'(busy_out),        32'd0);

      // Reset while holding a word
      enable_in = 1; result_ready_in = 0;
      wait_valid(10, "rst_hold_valid");
      check("rst_hold_word", 32'(result_data_out), 32'h00055555);
      rst_in = 1; run(1); rst_in = 0; enable_in = 0;
      check("rst_hold_v", 32'(result_valid_out), 32'd0);
      check("rst_hold_c", 32'(read_count_out),   32'd0);
      check("rst_hold_b", 32'(busy_out),         32'd0);
      run(2);

`ifdef WA_READOUT_TIMEOUT_EN
      // Timeout drops the word; a handshake on the last cycle wins
      tmo_pulses = 0; enable_in = 1; result_ready_in = 0;
      fifo_q.push_back(20'h66666);
      wait_valid(10, "tmo_valid");
      run(int'(TMO) + 4);
      check("tmo_pulses", 32'(tmo_pulses),       32'd1);
      check("tmo_valid0", 32'(result_valid_out), 32'd0);
      check("tmo_count",  32'(read_count_out),   32'd0);
      fifo_q.push_back(20'h77777);
      wait_valid(10, "tmo_valid2");
      run(int'(TMO) - 1);
      result_ready_in = 1;
      run(1);
      result_ready_in = 0;
      run(3);
      check("tmo_last_pulses", 32'(tmo_pulses),     32'd1);
      check("tmo_last_count",  32'(read_count_out), 32'd1);
`endif

      enable_in = 0;
      run(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_analysis_readout_ctrl.md
Name: window_analysis_readout_ctrl

Overview:
- Drains the window_analysis result FIFO autonomously: watches FIFO state flags, issues single-cycle read strobes, and waits the fixed FIFO read latency.
- Captures each result word and presents it downstream on a valid/ready handshake.
- Sits between window_analysis (read_enable_in / read_data_out / fifo_state_out) and the host/packet interface.
- Also reports a sticky FIFO-overflow flag and a count of delivered words.

Parameters:
- READ_DATA_SIZE, 20, width of one FIFO result word ({cycle_number, zero_offset, max_amp, max_time}).
- FIFO_STATE_SIZE, 4, width of FIFO state bus: [3] full, [2] empty, [1] almost_full, [0] almost_empty.
- READ_LATENCY, 2, clk cycles from the read strobe edge to valid FIFO data; legal range 1..7.
- COUNT_SIZE, 16, width of the delivered-word counter.
- TIMEOUT_CYCLES, 64, HOLD timeout; used only when WA_READOUT_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_in  in  1  synchronous reset, active-high.
- enable_in  in  1  level; 1 = controller may start new reads.
- fifo_state_in  in  FIFO_STATE_SIZE  FIFO flags from window_analysis.
- fifo_data_in  in  READ_DATA_SIZE  FIFO read data from window_analysis.
- fifo_read_enable_out  out  1  one-cycle read strobe to window_analysis.
- result_data_out  out  READ_DATA_SIZE  captured result word.
- result_valid_out  out  1  result_data_out holds an undelivered word.
- result_ready_in  in  1  downstream accepts the word when valid && ready.
- clear_overflow_in  in  1  clears overflow_out.
- overflow_out  out  1  sticky; set when the FIFO full flag is seen.
- read_count_out  out  COUNT_SIZE  delivered-word count, wraps modulo 2^COUNT_SIZE.
- busy_out  out  1  1 in any state other than IDLE.
- timeout_out  out  1  one-cycle pulse when a word is dropped (timeout feature only).

Behaviour:
- Reset (rst_in=1 at an edge): state=IDLE and all outputs 0, including result_data_out. Reset mid-transaction aborts it; a captured word is lost; an in-flight FIFO read is not recovered.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE -> ISSUE when enable_in=1 and fifo_state_in[2]=0. Otherwise stay in IDLE.
- ISSUE: fifo_read_enable_out=1 for exactly this one cycle; next state WAIT with the latency counter loaded to READ_LATENCY-1.
- WAIT: counter decrements each cycle. At the edge where it reaches 0, register fifo_data_in into result_data_out, set result_valid_out=1, next state HOLD.
- Timing: strobe high in cycle T; data captured at the edge ending cycle T+READ_LATENCY; valid is visible in cycle T+READ_LATENCY+1.
- HOLD: result_data_out and result_valid_out are stable while result_ready_in=0. On valid && ready at an edge: result_valid_out<=0, read_count_out<=read_count_out+1 (wraps 0xFFFF->0), next state IDLE.
- The mandatory IDLE cycle lets the empty flag settle after a read. Peak throughput is one word per READ_LATENCY+3 cycles.
- enable_in is only examined in IDLE. Dropping it mid-transaction lets that transaction complete, then the FSM stays in IDLE.
- The FSM never reads while the empty flag is high. The empty flag is ignored outside IDLE.
- overflow_out:
  - set on any edge with fifo_state_in[3]=1;
  - otherwise cleared by clear_overflow_in=1;
  - if full and clear coincide, set wins.
- busy_out = (state != IDLE), registered with the state.

Optional Feature:
- Macro WA_READOUT_TIMEOUT_EN.
- Defined: a HOLD-cycle counter starts at 0 on HOLD entry. If ready is not seen for TIMEOUT_CYCLES consecutive HOLD cycles, then:
  - the word is dropped and result_valid_out<=0;
  - timeout_out pulses for 1 cycle;
  - read_count_out is unchanged;
  - the FSM returns to IDLE.
  A handshake on the final cycle wins over the timeout.
- Undefined: HOLD waits indefinitely, timeout_out is tied to 0, and no counter logic is generated.

Test Plan:
- Reset and empty FIFO: rst_in=1 for 3 cycles, then enable_in=1 with empty=1 for 20 cycles -> all outputs remain 0, no read strobe, busy_out=0.
- Single read, READ_LATENCY=2, ready tied 1:
  - empty=0 with fifo_data_in=20'hA5C3F valid 2 cycles after the strobe;
  - required: strobe 1 cycle wide, result_data_out=20'hA5C3F, valid 1 cycle, read_count_out=1.
- Backpressure: 3 words preloaded, ready=0 for 10 cycles then 1 -> word 1 held stable for the 10 cycles, exactly 3 strobes total, words delivered in order, read_count_out=3, then empty=1 and the FSM idles.
- Overflow:
  - full=1 for 1 cycle -> overflow_out=1 and stays 1;
  - clear_overflow_in pulse -> 0;
  - full and clear asserted together -> stays 1.
- Mid-operation events: enable_in dropped during WAIT -> word still delivered, no further strobes. rst_in asserted in HOLD -> next cycle valid=0, count=0, state IDLE.
- Timeout (WA_READOUT_TIMEOUT_EN, TIMEOUT_CYCLES=8): ready=0 throughout -> after 8 HOLD cycles timeout_out pulses 1 cycle, valid drops, count unchanged. Ready asserted on the 8th cycle -> delivered, no pulse.
